// File: rtl/fv_req_arbiter.sv
// fv_req_arbiter: holds one FV fetch request per PE, grants round-robin into the FV FIFO.
// Define FV_REQ_STALL_CNT_EN to add the stall_cnt output.
module fv_req_arbiter #(
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 8,
  parameter int MAX_FV_NUM = 256,
  localparam int TAG_W = $clog2(NUM_PE),
  localparam int NFV_W = $clog2(MAX_FV_NUM)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NFV_W-1:0]         Num_FV,
  input  logic [NUM_PE-1:0]        req_valid,
  input  logic [NUM_PE*ADDR_W-1:0] req_addr,
  output logic [NUM_PE-1:0]        req_ready,
  input  logic                     fifo_wfull,
  output logic                     out_valid,
  output logic [TAG_W-1:0]         out_pe_tag,
  output logic [ADDR_W-1:0]        out_fv_addr,
  output logic                     err_oob,
  output logic [TAG_W-1:0]         err_pe_tag
`ifdef FV_REQ_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);
  localparam int CW = ADDR_W > NFV_W ? ADDR_W : NFV_W;
  logic [NUM_PE-1:0] pending, in_range;
  logic [ADDR_W-1:0] addr_q [NUM_PE];
  logic [TAG_W-1:0] rr_ptr, g;
  logic any_pend;
  assign any_pend = |pending;
  assign req_ready = ~pending;
  assign out_valid = any_pend && !fifo_wfull;
  assign out_pe_tag = g;
  assign out_fv_addr = any_pend ? addr_q[g] : '0;
  // descending scan so the pending PE closest to rr_ptr wins
  always_comb begin
    g = '0;
    for (int k = NUM_PE - 1; k >= 0; k--)
      if (pending[rr_ptr + TAG_W'(k)]) g = rr_ptr + TAG_W'(k);
    for (int i = 0; i < NUM_PE; i++)
      in_range[i] = CW'(req_addr[i*ADDR_W +: ADDR_W]) < CW'(Num_FV);
  end
  // descending loop so the lowest-index PE wins a simultaneous first error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      rr_ptr <= '0;
      err_oob <= 1'b0;
      err_pe_tag <= '0;
      for (int i = 0; i < NUM_PE; i++) addr_q[i] <= '0;
    end else begin
      if (out_valid) rr_ptr <= g + 1'b1;
      for (int i = NUM_PE - 1; i >= 0; i--) begin
        if (out_valid && g == TAG_W'(i)) pending[i] <= 1'b0;
        else if (req_valid[i] && !pending[i] && in_range[i]) begin
          pending[i] <= 1'b1;
          addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
        end
        if (req_valid[i] && !pending[i] && !in_range[i] && !err_oob) begin
          err_oob <= 1'b1;
          err_pe_tag <= TAG_W'(i);
        end
      end
    end
`ifdef FV_REQ_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cnt <= '0;
    else if (any_pend && fifo_wfull && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_fv_req_arbiter.sv
// tb_fv_req_arbiter: directed scenario tasks with hand-computed expectations for fv_req_arbiter.
module tb_fv_req_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] Num_FV = 8'd200;
  logic [3:0] req_valid = '0;
  logic [31:0] req_addr = '0;
  logic [3:0] req_ready;
  logic fifo_wfull = 1'b0;
  logic out_valid;
  logic [1:0] out_pe_tag;
  logic [7:0] out_fv_addr;
  logic err_oob;
  logic [1:0] err_pe_tag;
  int n_chk = 0;
  int n_fail = 0;
`ifdef FV_REQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  fv_req_arbiter #(.NUM_PE(4), .ADDR_W(8), .MAX_FV_NUM(256)) dut (
    .clk(clk), .reset(reset), .Num_FV(Num_FV), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .fifo_wfull(fifo_wfull), .out_valid(out_valid),
    .out_pe_tag(out_pe_tag), .out_fv_addr(out_fv_addr), .err_oob(err_oob), .err_pe_tag(err_pe_tag)
`ifdef FV_REQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a);
    req_valid[i] = 1'b1;
    req_addr[i*8 +: 8] = a;
  endtask

  task automatic test_reset();
    tick();
    n_chk++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL reset_ready got %h exp f", req_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_chk++; if (out_pe_tag !== 2'd0 || out_fv_addr !== 8'd0) begin n_fail++; $display("FAIL reset_out got tag %0d addr %h exp 0 0", out_pe_tag, out_fv_addr); end
    n_chk++; if (err_oob !== 1'b0 || err_pe_tag !== 2'd0) begin n_fail++; $display("FAIL reset_err got %b %0d exp 0 0", err_oob, err_pe_tag); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(2, 8'h10);
    tick();
    req_valid = '0;
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd2, 8'h10}) begin n_fail++; $display("FAIL single_out got v%b t%0d a%h exp v1 t2 a10", out_valid, out_pe_tag, out_fv_addr); end
    n_chk++; if (req_ready !== 4'b1011) begin n_fail++; $display("FAIL single_ready_low got %b exp 1011", req_ready); end
    tick();
    n_chk++; if (req_ready !== 4'hF || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_ready_high got r%b v%b exp r1111 v0", req_ready, out_valid); end
  endtask

  task automatic test_all_four();
    reset = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1));
    tick();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'(k), 8'(k + 1)}) begin n_fail++; $display("FAIL all4_grant%0d got v%b t%0d a%h exp v1 t%0d a%h", k, out_valid, out_pe_tag, out_fv_addr, k, k + 1); end
      tick();
    end
    n_chk++; if (out_valid !== 1'b0 || req_ready !== 4'hF) begin n_fail++; $display("FAIL all4_idle got v%b r%b exp v0 r1111", out_valid, req_ready); end
    set_req(0, 8'h30);
    set_req(3, 8'h33);
    tick();
    req_valid = '0;
    n_chk++; if (out_pe_tag !== 2'd0 || out_fv_addr !== 8'h30) begin n_fail++; $display("FAIL all4_rrptr0 got t%0d a%h exp t0 a30", out_pe_tag, out_fv_addr); end
    tick();
    n_chk++; if (out_pe_tag !== 2'd3 || out_fv_addr !== 8'h33) begin n_fail++; $display("FAIL all4_next got t%0d a%h exp t3 a33", out_pe_tag, out_fv_addr); end
    tick();
  endtask

  task automatic test_backpressure();
    fifo_wfull = 1'b1;
    set_req(0, 8'h20);
    set_req(1, 8'h21);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (out_valid !== 1'b0 || req_ready !== 4'b1100) begin n_fail++; $display("FAIL stall%0d got v%b r%b exp v0 r1100", k, out_valid, req_ready); end
      tick();
    end
    fifo_wfull = 1'b0;
`ifdef FV_REQ_STALL_CNT_EN
    n_chk++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL stall_cnt got %0d exp 5", stall_cnt); end
`endif
    #1;
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd0, 8'h20}) begin n_fail++; $display("FAIL unstall0 got v%b t%0d a%h exp v1 t0 a20", out_valid, out_pe_tag, out_fv_addr); end
    tick();
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd1, 8'h21}) begin n_fail++; $display("FAIL unstall1 got v%b t%0d a%h exp v1 t1 a21", out_valid, out_pe_tag, out_fv_addr); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unstall_idle got %b exp 0", out_valid); end
  endtask

  task automatic test_oob();
    set_req(3, 8'd200);
    tick();
    req_valid = '0;
    n_chk++; if (out_valid !== 1'b0 || err_oob !== 1'b1 || err_pe_tag !== 2'd3) begin n_fail++; $display("FAIL oob_first got v%b e%b t%0d exp v0 e1 t3", out_valid, err_oob, err_pe_tag); end
    n_chk++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL oob_ready3 got %b exp 1111", req_ready); end
    set_req(1, 8'd250);
    tick();
    req_valid = '0;
    n_chk++; if (out_valid !== 1'b0 || err_oob !== 1'b1 || err_pe_tag !== 2'd3) begin n_fail++; $display("FAIL oob_second got v%b e%b t%0d exp v0 e1 t3", out_valid, err_oob, err_pe_tag); end
    n_chk++; if (req_ready !== 4'hF) begin n_fail++; $display("FAIL oob_ready1 got %b exp 1111", req_ready); end
    set_req(0, 8'd199);
    tick();
    req_valid = '0;
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd0, 8'd199}) begin n_fail++; $display("FAIL oob_edge199 got v%b t%0d a%0d exp v1 t0 a199", out_valid, out_pe_tag, out_fv_addr); end
    tick();
  endtask

  task automatic test_fairness();
    set_req(1, 8'h05);
    tick();
    req_valid = '0;
    n_chk++; if (out_pe_tag !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fair_pe1 got v%b t%0d exp v1 t1", out_valid, out_pe_tag); end
    tick();
    set_req(0, 8'h07);
    set_req(3, 8'h08);
    tick();
    req_valid = '0;
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd3, 8'h08}) begin n_fail++; $display("FAIL fair_pe3 got v%b t%0d a%h exp v1 t3 a08", out_valid, out_pe_tag, out_fv_addr); end
    tick();
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd0, 8'h07}) begin n_fail++; $display("FAIL fair_pe0 got v%b t%0d a%h exp v1 t0 a07", out_valid, out_pe_tag, out_fv_addr); end
    tick();
  endtask

  task automatic test_mid_reset();
    set_req(0, 8'h40);
    set_req(1, 8'h41);
    set_req(2, 8'h42);
    tick();
    req_valid = '0;
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd1, 8'h41}) begin n_fail++; $display("FAIL mid_pre got v%b t%0d a%h exp v1 t1 a41", out_valid, out_pe_tag, out_fv_addr); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0 || req_ready !== 4'hF) begin n_fail++; $display("FAIL mid_async got v%b r%b exp v0 r1111", out_valid, req_ready); end
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_quiet%0d got %b exp 0", k, out_valid); end
    end
    set_req(2, 8'h09);
    tick();
    req_valid = '0;
    n_chk++; if ({out_valid, out_pe_tag, out_fv_addr} !== {1'b1, 2'd2, 8'h09}) begin n_fail++; $display("FAIL mid_new got v%b t%0d a%h exp v1 t2 a09", out_valid, out_pe_tag, out_fv_addr); end
    tick();
  endtask

  task automatic test_num_fv_zero();
    Num_FV = 8'd0;
    set_req(1, 8'd0);
    tick();
    req_valid = '0;
    n_chk++; if (out_valid !== 1'b0 || err_oob !== 1'b1 || err_pe_tag !== 2'd1) begin n_fail++; $display("FAIL nfv0 got v%b e%b t%0d exp v0 e1 t1", out_valid, err_oob, err_pe_tag); end
    Num_FV = 8'd200;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_oob();
    test_fairness();
    test_mid_reset();
    test_num_fv_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fv_req_arbiter.md
Name: fv_req_arbiter

Overview:
- Upstream feeder of the FV SRAM subsystem's request FIFO.
- Collects feature-vector fetch requests from NUM_PE edge PEs and holds one pending request per PE.
- Arbitrates among pending requests round-robin and emits at most one {valid, PE_tag, FV_addr} write per cycle into the FV sync FIFO. The FIFO uses the valid bit directly as its write enable, so the block honours that FIFO's wfull.
- Drops out-of-range addresses (addr >= Num_FV) and records them in a sticky error flag.

Parameters:
- NUM_PE, 4: number of edge PEs (requesters); power of two, >= 2.
- ADDR_W, 8: FV address width.
- MAX_FV_NUM, 256: maximum FV count. Num_FV width is $clog2(MAX_FV_NUM).
- TAG_W (localparam): $clog2(NUM_PE); PE_tag width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Num_FV  in  $clog2(MAX_FV_NUM)  number of valid FVs; quasi-static.
- req_valid  in  NUM_PE  per-PE request strobe.
- req_addr  in  NUM_PE*ADDR_W  per-PE FV address; PE i uses bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_PE  per-PE ready; equals ~pending[i].
- fifo_wfull  in  1  FV FIFO full.
- out_valid  out  1  FIFO write strobe; connects to the FIFO's wdata.valid.
- out_pe_tag  out  TAG_W  tag of the granted PE.
- out_fv_addr  out  ADDR_W  address of the granted request.
- err_oob  out  1  sticky: an out-of-range request was seen.
- err_pe_tag  out  TAG_W  PE that raised the first out-of-range error.

Behaviour:
- State:
  - pending[NUM_PE], a 1-bit flag per PE.
  - addr_q[NUM_PE], ADDR_W bits per PE.
  - rr_ptr, TAG_W bits.
  - err_oob, err_pe_tag.
- Reset (asynchronous, immediate):
  - pending=0, addr_q=0, rr_ptr=0, err_oob=0, err_pe_tag=0.
  - Outputs therefore reset to: req_ready=all 1, out_valid=0, out_pe_tag=0, out_fv_addr=0.
  - A reset asserted mid-operation discards all pending requests; no FIFO write is issued in the reset cycle.
- Capture, per PE i, on a clock edge where req_valid[i] && req_ready[i]:
  - If req_addr_i < Num_FV: pending[i] <= 1 and addr_q[i] <= req_addr_i.
  - Otherwise: the request is consumed but dropped and pending stays 0. If err_oob==0: err_oob <= 1 and err_pe_tag <= i. Later errors do not overwrite err_pe_tag.
  - req_valid while req_ready==0 is ignored; the PE must hold the request.
- Arbitration, combinational from registered state:
  - g = first i with pending[i]==1, searching rr_ptr, rr_ptr+1, ... modulo NUM_PE.
  - out_valid = (|pending) && !fifo_wfull.
  - out_pe_tag = g and out_fv_addr = addr_q[g]; both are 0 when no request is pending.
- Grant update, on a clock edge with out_valid==1:
  - pending[g] <= 0.
  - rr_ptr <= g+1, wrapping from NUM_PE-1 to 0.
- Stall:
  - When fifo_wfull==1: out_valid=0, pending and rr_ptr hold, and new captures into free slots still occur.
  - When fifo_wfull falls, out_valid may assert in the same cycle.
- Latency:
  - A request accepted at edge N is visible on out_valid in cycle N+1 at the earliest.
- Throughput:
  - The block issues one FIFO write per cycle overall.
  - Each PE can have at most one request in flight. A PE's ready rises only in the cycle after its grant (no same-cycle bypass), so a single PE can issue at most one request every 2 cycles.
- Fairness:
  - With all PEs continuously pending, grants rotate 0,1,2,...,NUM_PE-1,0,...
  - No PE waits more than NUM_PE non-stalled cycles.
- Simultaneous events:
  - A capture into PE i and a grant of PE j!=i in the same cycle are independent.
  - A capture into PE g cannot coincide with g's grant, because its ready is low.
- Num_FV==0: every request is out of range.

Optional Feature:
- Macro FV_REQ_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits.
  - stall_cnt is a saturating counter of cycles with (|pending) && fifo_wfull. It holds at 16'hFFFF once reached.
  - Reset value is 0; cleared only by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan (NUM_PE=4, ADDR_W=8, Num_FV=200):
- Reset then single request: PE2 req addr 0x10 at edge N → cycle N+1 has out_valid=1, tag=2, addr=0x10; req_ready[2]=0 in cycle N+1 and =1 in cycle N+2.
- All four PEs request simultaneously, rr_ptr=0, addrs 1,2,3,4 → four consecutive writes with tags 0,1,2,3 and matching addrs; rr_ptr=0 afterwards.
- Backpressure: PE0 and PE1 pending, fifo_wfull=1 for 5 cycles → out_valid=0 throughout with no state change; wfull falls → tag 0 written, then tag 1 in the next cycle. With FV_REQ_STALL_CNT_EN defined, stall_cnt=5.
- Out-of-range: PE3 addr 200, then PE1 addr 250 → no FIFO writes; err_oob=1, err_pe_tag=3; both PEs ready again in the next cycle.
- Fairness rotation: after a grant to PE1 (rr_ptr=2), PE0 and PE3 pending → grant PE3 first, then PE0.
- Reset mid-operation: three PEs pending, reset asserted between edges → out_valid drops immediately, req_ready=4'b1111, no writes after reset release until a new request arrives.
